// File: rtl/mire_writer.sv
// mire_writer -- Wishbone classic write master that paints a scrolling
// colour-bar / grid test pattern into the SDRAM framebuffer, one 32-bit word
// per pixel. The framebuffer is read by the VGA frame reader, so writes go out
// in bounded bursts separated by idle gaps to leave it bus bandwidth.
//
// Frame layout: pixel (x,y) lives at byte address 4*(y*HDISP+x), RGB in 23:0.
//
// Ports:
//   clk         system / Wishbone clock
//   rst_n       asynchronous active-low reset
//   enable      level; 1 keeps frames coming, 0 stops at the next burst boundary
//   cyc, stb    Wishbone cycle / strobe (always equal)
//   we, sel     constant 1 / 4'b1111
//   cti, bte    constant 0 (classic cycles)
//   adr         byte address of the pixel being written
//   dat_ms      write data {8'h00, R, G, B} for the pixel at adr
//   ack         Wishbone acknowledge, one word committed per ack
//   frame_done  one-cycle pulse after the last pixel of a frame is acked
//   frame_cnt   completed frames, wraps modulo 256
module mire_writer #(
    parameter int HDISP       = 800,
    parameter int VDISP       = 480,
    parameter int GRID        = 16,
    parameter int BURST       = 64,
    parameter int PAUSE       = 64,
    parameter int SCROLL_STEP = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    output logic        cyc,
    output logic        stb,
    output logic        we,
    output logic [3:0]  sel,
    output logic [2:0]  cti,
    output logic [1:0]  bte,
    output logic [31:0] adr,
    output logic [31:0] dat_ms,
    input  logic        ack,
    output logic        frame_done,
    output logic [7:0]  frame_cnt
);

    localparam int X_W  = $clog2(HDISP);
    localparam int Y_W  = $clog2(VDISP);
    localparam int BC_W = $clog2(BURST + 1);
    localparam int PC_W = $clog2(PAUSE + 1);

    localparam logic [X_W-1:0]  X_LAST   = X_W'(HDISP - 1);
    localparam logic [Y_W-1:0]  Y_LAST   = Y_W'(VDISP - 1);
    localparam logic [X_W:0]    HD_EXT   = (X_W + 1)'(HDISP);
    localparam logic [X_W:0]    STEP_EXT = (X_W + 1)'(SCROLL_STEP);
    localparam logic [BC_W-1:0] BC_LAST  = BC_W'(BURST - 1);
    localparam logic [PC_W-1:0] PC_LAST  = PC_W'(PAUSE - 1);

    // Pixel (0,0) always sits on a grid line, whatever the scroll.
    localparam logic [31:0] PIX_ORIGIN = 32'h00FF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE,
        ST_PAUSE
    } state_t;

    state_t          state;
    logic [X_W-1:0]  x;
    logic [Y_W-1:0]  y;
    logic [X_W-1:0]  scroll;
    logic [BC_W-1:0] burst_cnt;
    logic [PC_W-1:0] pause_cnt;

    logic [X_W-1:0]  x_nxt;
    logic [Y_W-1:0]  y_nxt;
    logic [X_W-1:0]  scroll_nxt;
    logic [31:0]     adr_nxt;
    logic [X_W:0]    scroll_sum;
    logic            ack_ok;
    logic            frame_last;

    // Test pattern for one pixel. Arithmetic is done in 32-bit int so the
    // xs*8 product cannot overflow for any sensible HDISP.
    function automatic logic [31:0] pattern(input logic [X_W-1:0] px,
                                            input logic [Y_W-1:0] py,
                                            input logic [X_W-1:0] sc);
        int         xs;
        logic [2:0] bar;
        if ((int'(px) % GRID) == 0 || (int'(py) % GRID) == 0) begin
            pattern = 32'h00FF_FFFF;
        end else begin
            xs = int'(px) + int'(sc);
            if (xs >= HDISP) xs = xs - HDISP;
            bar = 3'((xs * 8) / HDISP);
            pattern = {8'h00, {8{bar[2]}}, {8{bar[1]}}, {8{bar[0]}}};
        end
    endfunction

    assign stb = cyc;
    assign we  = 1'b1;
    assign sel = 4'b1111;
    assign cti = 3'b000;
    assign bte = 2'b00;

    // Acks outside WRITE (cyc low) are ignored.
    assign ack_ok     = (state == ST_WRITE) && ack;
    assign frame_last = ack_ok && (x == X_LAST) && (y == Y_LAST);
    assign scroll_sum = {1'b0, scroll} + STEP_EXT;

    // Next pixel position. dat_ms is registered from these next-state values
    // so that it always describes the pixel at the registered adr.
    always_comb begin
        x_nxt      = x;
        y_nxt      = y;
        scroll_nxt = scroll;
        adr_nxt    = adr;
        if (ack_ok) begin
            if (x == X_LAST) begin
                x_nxt = '0;
                y_nxt = (y == Y_LAST) ? '0 : y + 1'b1;
            end else begin
                x_nxt = x + 1'b1;
            end
            adr_nxt = frame_last ? 32'd0 : adr + 32'd4;
            if (frame_last) begin
                scroll_nxt = (scroll_sum >= HD_EXT) ? X_W'(scroll_sum - HD_EXT)
                                                    : scroll_sum[X_W-1:0];
            end
        end
    end

    // Registered position, data and bus control
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cyc        <= 1'b0;
            x          <= '0;
            y          <= '0;
            scroll     <= '0;
            adr        <= 32'd0;
            dat_ms     <= PIX_ORIGIN;
            burst_cnt  <= '0;
            pause_cnt  <= '0;
            frame_done <= 1'b0;
            frame_cnt  <= 8'd0;
        end else begin
            x          <= x_nxt;
            y          <= y_nxt;
            scroll     <= scroll_nxt;
            adr        <= adr_nxt;
            dat_ms     <= pattern(x_nxt, y_nxt, scroll_nxt);
            frame_done <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (enable) begin
                        state     <= ST_WRITE;
                        cyc       <= 1'b1;
                        burst_cnt <= '0;
                    end
                end

                ST_WRITE: begin
                    if (ack) begin
                        if (frame_last) begin
                            frame_cnt  <= frame_cnt + 8'd1;
                            frame_done <= 1'b1;
                        end
                        // A frame end also closes the burst so the next frame
                        // starts with a full burst.
                        if (frame_last || burst_cnt == BC_LAST) begin
                            state     <= ST_PAUSE;
                            cyc       <= 1'b0;
                            burst_cnt <= '0;
                            pause_cnt <= '0;
                        end else begin
                            burst_cnt <= burst_cnt + 1'b1;
                        end
                    end
                end

                ST_PAUSE: begin
                    // enable is only honoured here, never mid-burst.
                    if (pause_cnt == PC_LAST) begin
                        pause_cnt <= '0;
                        if (enable) begin
                            state <= ST_WRITE;
                            cyc   <= 1'b1;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        pause_cnt <= pause_cnt + 1'b1;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                    cyc   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mire_writer.sv
// Testbench for mire_writer. A full-size instance checks burst/pause timing
// and hand-computed pixel values; a small instance runs whole frames, stalls,
// enable gating and asynchronous reset.
module tb_mire_writer;

    localparam int S_H    = 32;
    localparam int S_V    = 8;
    localparam int S_GRID = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // full-size instance
    logic        b_rst_n, b_enable, b_ack;
    logic        b_cyc, b_stb, b_we, b_fd;
    logic [3:0]  b_sel;
    logic [2:0]  b_cti;
    logic [1:0]  b_bte;
    logic [31:0] b_adr, b_dat;
    logic [7:0]  b_fc;

    // small instance
    logic        s_rst_n, s_enable, s_ack;
    logic        s_cyc, s_stb, s_we, s_fd;
    logic [3:0]  s_sel;
    logic [2:0]  s_cti;
    logic [1:0]  s_bte;
    logic [31:0] s_adr, s_dat;
    logic [7:0]  s_fc;

    mire_writer u_big (
        .clk(clk), .rst_n(b_rst_n), .enable(b_enable),
        .cyc(b_cyc), .stb(b_stb), .we(b_we), .sel(b_sel), .cti(b_cti), .bte(b_bte),
        .adr(b_adr), .dat_ms(b_dat), .ack(b_ack),
        .frame_done(b_fd), .frame_cnt(b_fc)
    );

    mire_writer #(
        .HDISP(S_H), .VDISP(S_V), .GRID(S_GRID),
        .BURST(16), .PAUSE(3), .SCROLL_STEP(4)
    ) u_small (
        .clk(clk), .rst_n(s_rst_n), .enable(s_enable),
        .cyc(s_cyc), .stb(s_stb), .we(s_we), .sel(s_sel), .cti(s_cti), .bte(s_bte),
        .adr(s_adr), .dat_ms(s_dat), .ack(s_ack),
        .frame_done(s_fd), .frame_cnt(s_fc)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_badr(input string tag, input logic [31:0] target);
        int n;
        n = 0;
        while (b_adr !== target && n < 20000) begin
            step();
            n++;
        end
        chk({tag, "_reach"}, 32'(b_adr === target), 32'd1);
    endtask

    // Expected pixel word for the small instance at byte address a.
    function automatic logic [31:0] mpix(input logic [31:0] a, input int sc);
        int idx, px, py, xs, bar;
        idx = int'(a >> 2);
        px  = idx % S_H;
        py  = idx / S_H;
        if (px % S_GRID == 0 || py % S_GRID == 0) return 32'h00FFFFFF;
        xs  = (px + sc) % S_H;
        bar = (xs * 8) / S_H;
        return {8'h00, (bar[2] ? 8'hFF : 8'h00), (bar[1] ? 8'hFF : 8'h00), (bar[0] ? 8'hFF : 8'h00)};
    endfunction

    initial begin
        int          n, acks, fd_cnt, mism, stab_bad, words, stall_left, k, cyc_cnt;
        logic        prev_stalled;
        logic [31:0] prev_adr, prev_dat;

        b_rst_n = 1'b0; b_enable = 1'b0; b_ack = 1'b0;
        s_rst_n = 1'b0; s_enable = 1'b0; s_ack = 1'b0;
        repeat (3) step();

        chk("b_rst_cyc", 32'(b_cyc), 32'd0);
        chk("b_rst_adr", b_adr, 32'd0);
        chk("b_rst_dat", b_dat, 32'h00FFFFFF);
        chk("b_rst_fcnt", 32'(b_fc), 32'd0);
        chk("b_rst_fdone", 32'(b_fd), 32'd0);
        chk("b_const", 32'({b_stb, b_we, b_sel, b_cti, b_bte}), 32'({1'b0, 1'b1, 4'hF, 3'd0, 2'd0}));

        b_rst_n = 1'b1;
        step();
        chk("b_idle_cyc", 32'(b_cyc), 32'd0);

        // ack held high: the ack on the IDLE->WRITE edge must be ignored
        b_enable = 1'b1;
        b_ack    = 1'b1;
        step();
        chk("b_latency_cyc", 32'(b_cyc), 32'd1);
        chk("b_first_adr", b_adr, 32'd0);
        chk("b_first_dat", b_dat, 32'h00FFFFFF);

        n = 0;
        while (b_cyc && n < 200) begin n++; step(); end
        chk("b_burst_len", 32'(n), 32'd64);
        n = 0;
        while (!b_cyc && n < 200) begin n++; step(); end
        chk("b_pause_len", 32'(n), 32'd64);
        chk("b_burst2_adr", b_adr, 32'd256);

        wait_badr("b_p1_1", 32'd3204);   chk("b_pix_1_1",   b_dat, 32'h00000000);
        wait_badr("b_p99_1", 32'd3596);  chk("b_pix_99_1",  b_dat, 32'h00000000);
        wait_badr("b_p101_1", 32'd3604); chk("b_pix_101_1", b_dat, 32'h000000FF);
        wait_badr("b_p401_1", 32'd4804); chk("b_pix_401_1", b_dat, 32'h00FF0000);
        wait_badr("b_p799_1", 32'd6396); chk("b_pix_799_1", b_dat, 32'h00FFFFFF);
        b_enable = 1'b0;

        // small instance, frame 1 with an always-ack slave
        s_rst_n  = 1'b1;
        s_enable = 1'b1;
        s_ack    = 1'b1;
        acks = 0; fd_cnt = 0; mism = 0; n = 0;
        while (acks < 256 && n < 2000) begin
            if (s_cyc) begin
                if (s_dat !== mpix(s_adr, 0)) mism++;
                acks++;
            end
            step();
            n++;
            if (s_fd) fd_cnt++;
        end
        chk("s_f1_acks", 32'(acks), 32'd256);
        chk("s_f1_image", 32'(mism), 32'd0);
        chk("s_f1_fdone_now", 32'(s_fd), 32'd1);
        chk("s_f1_fdone_cnt", 32'(fd_cnt), 32'd1);
        chk("s_f1_fcnt", 32'(s_fc), 32'd1);
        chk("s_f1_adr_wrap", s_adr, 32'd0);
        chk("s_f1_cyc_drop", 32'(s_cyc), 32'd0);
        step();
        chk("s_f1_fdone_pulse", 32'(s_fd), 32'd0);

        // frame 2 (scroll 4) with random 0..5 cycle ack stalls
        words = 0; mism = 0; stab_bad = 0; prev_stalled = 1'b0; n = 0;
        prev_adr = '0; prev_dat = '0;
        stall_left = int'($urandom_range(0, 5));
        while (words < 256 && n < 5000) begin
            if (prev_stalled && (s_cyc !== 1'b1 || s_adr !== prev_adr || s_dat !== prev_dat))
                stab_bad++;
            prev_stalled = 1'b0;
            if (s_cyc) begin
                if (stall_left > 0) begin
                    s_ack        = 1'b0;
                    stall_left--;
                    prev_stalled = 1'b1;
                    prev_adr     = s_adr;
                    prev_dat     = s_dat;
                end else begin
                    s_ack = 1'b1;
                    if (s_dat !== mpix(s_adr, 4)) mism++;
                    if (s_adr == 32'd132) chk("s_f2_pix_1_1", s_dat, 32'h000000FF);
                    words++;
                    stall_left = int'($urandom_range(0, 5));
                end
            end else begin
                s_ack = 1'($urandom_range(0, 1));
            end
            step();
            n++;
        end
        chk("s_f2_words", 32'(words), 32'd256);
        chk("s_f2_image", 32'(mism), 32'd0);
        chk("s_f2_stall_hold", 32'(stab_bad), 32'd0);
        chk("s_f2_fcnt", 32'(s_fc), 32'd2);

        // enable dropped mid-burst: burst completes, then idle
        s_ack = 1'b1;
        k = 0;
        while (!s_cyc && k < 20) begin step(); k++; end
        chk("s_f3_start_cyc", 32'(s_cyc), 32'd1);
        chk("s_f3_start_adr", s_adr, 32'd0);
        repeat (5) step();
        s_enable = 1'b0;
        n = 0;
        while (s_cyc && n < 50) begin n++; step(); end
        chk("s_dis_remaining", 32'(n), 32'd11);
        chk("s_dis_adr", s_adr, 32'd64);
        cyc_cnt = 0;
        repeat (12) begin
            if (s_cyc) cyc_cnt++;
            step();
        end
        chk("s_dis_idle", 32'(cyc_cnt), 32'd0);
        chk("s_dis_hold_adr", s_adr, 32'd64);
        s_enable = 1'b1;
        step();
        chk("s_reen_cyc", 32'(s_cyc), 32'd1);
        chk("s_reen_adr", s_adr, 32'd64);

        // asynchronous reset in the middle of a burst
        repeat (3) step();
        chk("s_rst_pre_cyc", 32'(s_cyc), 32'd1);
        s_rst_n = 1'b0;
        #1;
        chk("s_rst_async_cyc", 32'(s_cyc), 32'd0);
        chk("s_rst_adr", s_adr, 32'd0);
        chk("s_rst_fcnt", 32'(s_fc), 32'd0);
        chk("s_rst_dat", s_dat, 32'h00FFFFFF);
        chk("s_const", 32'({s_stb, s_we, s_sel, s_cti, s_bte}), 32'({1'b0, 1'b1, 4'hF, 3'd0, 2'd0}));
        step();
        s_rst_n = 1'b1;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
